inst_stream_fetch: RTL

- Synthesizable fetch front-end that replaces file-driven instruction feeding for the core.
- Accepts a byte stream over a valid/ready handshake (loader, UART or bench) and assembles bytes into DATA_WIDTH-bit instruction words with a build-time byte order.
- Tags each word with its fetch address and buffers it in a DEPTH-entry FIFO.
- Presents words to the core over valid/ready, with flush/redirect and end-of-stream drain reporting.

---
 rtl/inst_stream_fetch.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_stream_fetch.sv
// -----------------------------------------------------------------------------
// inst_stream_fetch
//
// Fetch front-end that takes a byte stream and turns it into instruction words
// for the core. Bytes arrive over a valid/ready handshake and are packed into
// DATA_WIDTH-bit words with a byte order fixed at build time. Each completed
// word is tagged with its fetch address and stored in a DEPTH-entry FIFO. The
// core reads words from the FIFO over valid/ready. Flush discards everything
// buffered and jumps to a new address. End of stream is reported once the
// FIFO has drained.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   byte_valid/ready  byte stream handshake
//   byte_data         stream byte
//   byte_last         marks the final byte; it closes a short word
//   inst_valid/ready  core handshake for the FIFO head
//   inst              head instruction (0 when inst_valid=0)
//   inst_address      head address, or the next assembly address when empty
//   flush             discard the FIFO and the partial word, then redirect
//   flush_address     new next-word address, sampled while flush=1
//   level             FIFO occupancy
//   done              stream has ended and the FIFO is empty
// -----------------------------------------------------------------------------
module inst_stream_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter bit                    BIG_ENDIAN = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_last,
  output logic                         byte_ready,
  output logic                         inst_valid,
  output logic [DATA_WIDTH-1:0]        inst,
  output logic [DATA_WIDTH-1:0]        inst_address,
  input  logic                         inst_ready,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        flush_address,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         done
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = $clog2(BPW);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [LW-1:0]         level_q, level_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DATA_WIDTH-1:0] mem_addr [DEPTH];

  logic [CW-1:0]         lane;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  full;
  logic                  completes;
  logic                  head_take;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign full       = (level_q == LW'(DEPTH));
  assign completes  = byte_last || (cnt_q == CW'(BPW - 1));
  assign head_take  = inst_valid && inst_ready;

  // A word-completing byte may enter a full FIFO only when the head leaves in
  // the same cycle; that is the inst_ready -> byte_ready combinational path.
  assign byte_ready = (state_q == ST_RUN) && !flush &&
                      (!completes || !full || head_take);

  assign accept     = byte_valid && byte_ready;
  assign push       = accept && completes;
  // Flush wins: the head is not consumed in a flush cycle.
  assign pop        = head_take && !flush;

  // Byte lane for the incoming byte; the partial word is zeroed after every
  // push, so lanes left unwritten by a short final word read as 0.
  assign lane = BIG_ENDIAN ? (CW'(BPW - 1) - cnt_q) : cnt_q;

  always_comb begin
    asm_word = word_q;
    asm_word[int'(lane) * 8 +: 8] = byte_data;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    state_d = state_q;

    if (flush) begin
      cnt_d   = '0;
      word_d  = '0;
      addr_d  = flush_address;
      rd_d    = '0;
      wr_d    = '0;
      level_d = '0;
      state_d = ST_RUN;
    end else begin
      if (accept) begin
        if (completes) begin
          cnt_d  = '0;
          word_d = '0;
          addr_d = addr_q + DATA_WIDTH'(BPW);
          wr_d   = wr_q + 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          word_d = asm_word;
        end
      end

      if (pop) begin
        rd_d = rd_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      case (state_q)
        ST_RUN:   if (accept && byte_last) state_d = ST_DRAIN;
        ST_DRAIN: if (level_q == '0)       state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= RESET_ADDR;
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only read after it has
  // been written, and inst is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_q] <= asm_word;
      mem_addr[wr_q] <= addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst_valid   = (level_q != '0);
  assign inst         = inst_valid ? mem_data[rd_q] : '0;
  assign inst_address = inst_valid ? mem_addr[rd_q] : addr_q;
  assign level        = level_q;
  assign done         = (state_q == ST_DONE);

endmodule
